// File: rtl/emm_ddr_32to8.sv
// Unpacks 33-bit {sof, data} record words into the 197-byte record stream.
// Optional saturating framing-error counter on err_cnt when EMM_32TO8_ERRCNT_EN is defined.
module emm_ddr_32to8 #(
   parameter int PAYLOAD_WORDS = 47
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        din_valid,
   input  logic [32:0] din,
   output logic        din_ready,
   output logic        dout_en,
   output logic [7:0]  dout,
   output logic        dout_sof,
   output logic        dout_eof,
   output logic        rec_err
`ifdef EMM_32TO8_ERRCNT_EN
   ,
   output logic [15:0] err_cnt
`endif
);

   localparam logic [5:0] LAST_W = 6'(PAYLOAD_WORDS + 3);

   typedef enum logic {SYNC, EMIT} state_t;

   state_t      state_q, state_d;
   logic [31:0] hold_q, hold_d;
   logic [5:0]  wcnt_q, wcnt_d;
   logic [1:0]  bidx_q, bidx_d;
   logic        en_d, sof_d, eof_d, err_d;
   logic [7:0]  dout_d;
   logic        accept, rec_end;

   // Index of the first (most significant) byte emitted for a word slot.
   function automatic logic [1:0] first_bidx(input logic [5:0] w);
      case (w)
         6'd0:    return 2'd1;
         6'd1:    return 2'd0;
         6'd3:    return 2'd1;
         default: return 2'd3;
      endcase
   endfunction

   // dout_en doubles as "hold_data occupied": bidx is the byte now on dout.
   assign din_ready = !dout_en || (bidx_q == 2'd0);
   assign accept    = din_valid && din_ready;
   assign rec_end   = dout_en && (bidx_q == 2'd0) && (wcnt_q == LAST_W);

   always_comb begin
      state_d = state_q;
      hold_d  = hold_q;
      wcnt_d  = wcnt_q;
      bidx_d  = bidx_q;
      en_d    = 1'b0;
      dout_d  = 8'd0;
      sof_d   = 1'b0;
      eof_d   = 1'b0;
      err_d   = 1'b0;
      if (state_q == EMIT && dout_en && bidx_q != 2'd0) begin
         bidx_d = bidx_q - 2'd1;
         en_d   = 1'b1;
         dout_d = hold_q[{bidx_d, 3'b000} +: 8];
         eof_d  = (wcnt_q == LAST_W) && (bidx_d == 2'd0);
      end else begin
         if (rec_end)
            state_d = SYNC;
         if (accept) begin
            if (din[32]) begin
               // A sof landing on the final byte of word 50 is a clean restart.
               err_d   = (state_q == EMIT) && !rec_end;
               state_d = EMIT;
               wcnt_d  = 6'd0;
               bidx_d  = 2'd1;
               hold_d  = din[31:0];
               en_d    = 1'b1;
               dout_d  = din[15:8];
               sof_d   = 1'b1;
            end else if (state_q == SYNC || rec_end) begin
               err_d   = 1'b1;
               state_d = SYNC;
            end else begin
               wcnt_d = wcnt_q + 6'd1;
               bidx_d = first_bidx(wcnt_d);
               hold_d = din[31:0];
               en_d   = 1'b1;
               dout_d = din[{bidx_d, 3'b000} +: 8];
               eof_d  = (wcnt_d == LAST_W) && (bidx_d == 2'd0);
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= SYNC;
         hold_q   <= '0;
         wcnt_q   <= '0;
         bidx_q   <= '0;
         dout_en  <= 1'b0;
         dout     <= '0;
         dout_sof <= 1'b0;
         dout_eof <= 1'b0;
         rec_err  <= 1'b0;
      end else begin
         state_q  <= state_d;
         hold_q   <= hold_d;
         wcnt_q   <= wcnt_d;
         bidx_q   <= bidx_d;
         dout_en  <= en_d;
         dout     <= dout_d;
         dout_sof <= sof_d;
         dout_eof <= eof_d;
         rec_err  <= err_d;
      end
   end

`ifdef EMM_32TO8_ERRCNT_EN
   always_ff @(posedge clk) begin
      if (rst)
         err_cnt <= '0;
      else if (rec_err && err_cnt != 16'hFFFF)
         err_cnt <= err_cnt + 16'd1;
   end
`endif

endmodule

// File: tb/tb_emm_ddr_32to8.sv
// Directed/randomized bench for emm_ddr_32to8 with a word-level record model.
module tb_emm_ddr_32to8;
   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        din_valid = 1'b0;
   logic [32:0] din = '0;
   logic        din_ready, dout_en, dout_sof, dout_eof, rec_err;
   logic [7:0]  dout;
`ifdef EMM_32TO8_ERRCNT_EN
   logic [15:0] err_cnt;
`endif

   emm_ddr_32to8 dut (
      .clk(clk), .rst(rst), .din_valid(din_valid), .din(din),
      .din_ready(din_ready), .dout_en(dout_en), .dout(dout),
      .dout_sof(dout_sof), .dout_eof(dout_eof), .rec_err(rec_err)
`ifdef EMM_32TO8_ERRCNT_EN
      , .err_cnt(err_cnt)
`endif
   );

   always #5 clk = ~clk;

   int checks = 0;
   int failures = 0;
   logic [32:0] acc_q[$];
   logic [9:0]  got_q[$];
   logic [9:0]  exp_q[$];
   int err_seen = 0, cur_run = 0, max_run = 0;
   logic [31:0] hdr [4] = '{32'h00001234, 32'h00000002, 32'hC0A80101, 32'h00001F90};

   always @(negedge clk) begin
      if (dout_en) begin
         got_q.push_back({dout_sof, dout_eof, dout});
         cur_run++;
         if (cur_run > max_run) max_run = cur_run;
      end else
         cur_run = 0;
      if (rec_err) err_seen++;
   end

   task automatic tick(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
      checks++;
      assert (obs === expv) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
      end
   endtask

   task automatic clear();
      acc_q.delete();
      got_q.delete();
      err_seen = 0;
      max_run  = 0;
   endtask

   task automatic chk_reset(input string tag);
      chk({tag, "_ready"}, din_ready, 1);
      chk({tag, "_en"}, dout_en, 0);
      chk({tag, "_dout"}, dout, 0);
      chk({tag, "_sof"}, dout_sof, 0);
      chk({tag, "_eof"}, dout_eof, 0);
      chk({tag, "_err"}, rec_err, 0);
`ifdef EMM_32TO8_ERRCNT_EN
      chk({tag, "_errcnt"}, err_cnt, 0);
`endif
   endtask

   // Present one word and hold it until the DUT takes it (bounded).
   task automatic send(input logic sof, input logic [31:0] d);
      int n = 0;
      din_valid = 1'b1;
      din = {sof, d};
      while (!din_ready && n < 50) begin
         @(negedge clk);
         n++;
      end
      if (n >= 50) chk("send_timeout", n, 0);
      else acc_q.push_back({sof, d});
      @(negedge clk);
      din_valid = 1'b0;
      din = '0;
   endtask

   task automatic send_rec(input int first, input int nw, input int gap, input bit chk_busy);
      logic [31:0] w;
      for (int i = first; i < nw; i++) begin
         if (i < 4) w = hdr[i];
         else if (i == 4) w = {8'h47, 24'($urandom)};
         else w = $urandom;
         send(i == 0, w);
         if (chk_busy && (i == 2 || i >= 4)) chk($sformatf("busy_ready_w%0d", i), din_ready, 0);
         tick(gap);
      end
   endtask

   // Record-level reference: 2+1+4+2+47*4 bytes, MSB first, sof restarts, stray words dropped.
   task automatic model(output int exp_err);
      bit in_rec = 0;
      int idx = 0, nb;
      logic [32:0] w;
      exp_q.delete();
      exp_err = 0;
      foreach (acc_q[j]) begin
         w = acc_q[j];
         if (w[32]) begin
            if (in_rec) exp_err++;
            in_rec = 1;
            idx = 0;
         end else if (!in_rec) begin
            exp_err++;
            continue;
         end else
            idx++;
         nb = (idx == 0 || idx == 3) ? 2 : (idx == 1) ? 1 : 4;
         for (int k = nb - 1; k >= 0; k--)
            exp_q.push_back({1'(idx == 0 && k == nb - 1), 1'(idx == 50 && k == 0), w[8*k +: 8]});
         if (idx == 50) in_rec = 0;
      end
   endtask

   task automatic compare(input string tag, input int exp_run);
      int exp_err, n;
      model(exp_err);
      chk({tag, "_nbytes"}, got_q.size(), exp_q.size());
      n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
      for (int i = 0; i < n; i++)
         chk($sformatf("%s_byte%0d", tag, i), got_q[i], exp_q[i]);
      chk({tag, "_rec_err"}, err_seen, exp_err);
      if (exp_run >= 0) chk({tag, "_run"}, max_run, exp_run);
   endtask

   initial begin
      rst = 1'b1;
      tick(3);
      chk_reset("reset");
      rst = 1'b0;
      tick(1);
      clear();

      // One record at full rate, first-byte latency
      send(1'b1, hdr[0]);
      chk("first_en", dout_en, 1);
      chk("first_byte", dout, 8'h12);
      chk("first_sof", dout_sof, 1);
      send_rec(1, 51, 0, 0);
      tick(10);
      compare("rec1", 197);

      // Two records back to back
      clear();
      send_rec(0, 51, 0, 0);
      send_rec(0, 51, 0, 0);
      tick(10);
      compare("rec2", 394);

      // Input valid with idle cycles in between
      clear();
      send_rec(0, 51, 1, 1);
      tick(10);
      compare("toggle", -1);

      // Stray non-sof word in SYNC
      clear();
      send(1'b0, 32'hDEADBEEF);
      chk("drop_err", rec_err, 1);
      chk("drop_en", dout_en, 0);
      tick(1);
      chk("drop_err_pulse", rec_err, 0);
      tick(2);
`ifdef EMM_32TO8_ERRCNT_EN
      chk("drop_errcnt", err_cnt, 1);
`endif
      compare("drop", -1);

      // Sof mid-record after payload word 10, then a stray word after the record
      clear();
      send_rec(0, 15, 0, 0);
      send_rec(0, 51, 0, 0);
      send(1'b0, $urandom);
      tick(10);
      compare("abort", -1);

      // Reset mid-payload, then a clean record
      clear();
      send_rec(0, 20, 0, 0);
      rst = 1'b1;
      tick(1);
      chk_reset("midrst");
      rst = 1'b0;
      clear();
      send_rec(0, 51, 0, 0);
      tick(10);
      compare("after_rst", 197);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
